id_branch_predictor: RTL and testbench
======================================

# id_branch_predictor

Parametrised branch prediction and resolution unit spanning IF and ID. IF gets a same-cycle prediction from a direct-mapped table of 2-bit saturating counters plus branch target buffer (BTB). ID resolves beq/bgez/bgtz/blez/bltz/bne, j and jr against forwarded operands, and raises a redirect on misprediction. Resolved outcomes train the table, and saturating counters track branches and mispredictions. PCs are word addresses throughout: PC+1 is the next instruction.

## Interface
- XLEN, 32, datapath/PC width
- IDX_W, 6, table index bits; depth 2^IDX_W entries
- TAG_W, 8, BTB tag bits taken from pc[IDX_W+TAG_W-1:IDX_W]
- CNT_W, 32, performance counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  XLEN  PC being fetched
- if_pred_taken  out  1  prediction for if_pc
- if_pred_target  out  XLEN  predicted next PC
- id_valid  in  1  ID holds a real instruction
- id_stall  in  1  ID held this cycle; no resolution effects
- id_pc  in  XLEN  PC of instruction in ID
- id_pred_taken  in  1  prediction carried from IF with this instruction
- id_pred_target  in  XLEN  prediction target carried from IF
- id_branch  in  1  conditional branch
- id_branch_op  in  3  0 beq, 1 bgez, 2 bgtz, 3 blez, 4 bltz, 5 bne, 6-7 never taken
- id_jump  in  1  j or jr
- id_jumpr  in  1  jr (qualified by id_jump)
- id_instr_index  in  26  j target field
- id_sign_imm  in  XLEN  sign-extended offset
- id_rs_val, id_rt_val  in  XLEN  forwarded operands
- id_redirect  out  1  misprediction; flush IF/ID, load id_redirect_pc
- id_redirect_pc  out  XLEN  correct next PC
- id_taken  out  1  actual outcome
- branch_cnt, mispredict_cnt  out  CNT_W  saturating statistics

## Operation
- Entry i: valid bit, TAG_W tag, XLEN target, 2-bit counter. index = pc[IDX_W-1:0].
- Lookup (combinational on if_pc): hit = valid & tag match. if_pred_taken = hit & ctr[1]. if_pred_target = if_pred_taken ? entry target : if_pc+1.
- Resolution (combinational):
  - pc_p1 = id_pc+1.
  - Conditional taken: compare signed as numbered ops.
  - target: branch pc_p1+id_sign_imm; j {pc_p1[31:28],2'b00,id_instr_index}; jr id_rs_val.
  - id_taken = id_jump | (id_branch & cond).
- Definitions:
  - act = id_valid & ~id_stall & (id_branch | id_jump).
  - mis = id_taken != id_pred_taken, or both taken and target != id_pred_target.
  - id_redirect = act & mis.
  - id_redirect_pc = id_taken ? target : pc_p1.
  - Non-branch, non-jump instructions predicted taken (stale aliasing) also redirect to pc_p1: id_redirect additionally covers id_valid & ~id_stall & ~id_branch & ~id_jump & id_pred_taken.
- Training, at rising edge when act:
  - Conditional, hit: ctr saturating +1 if taken, -1 if not. If taken, target rewritten.
  - Conditional, miss: if taken, allocate: valid=1, tag, target, ctr=2'b10. If not taken, no change.
  - j: allocate/overwrite with ctr=2'b11.
  - jr: no table write.
- Statistics: branch_cnt +1 per act; mispredict_cnt +1 per id_redirect. Both hold at all-ones.

## Timing
- Lookup and resolution: zero latency, same cycle.
- Table writes visible to lookup the cycle after the edge. A same-cycle lookup of the index being written returns the old entry; there is no bypass.
- Reset, asynchronous, any time: all valid=0, ctr=2'b01, targets/tags 0, counters 0. During reset if_pred_taken=0, if_pred_target=if_pc+1. id_redirect/id_taken remain combinational, but no state changes.
- id_stall=1: outputs still computed; id_redirect forced 0; no training; no counting.
- Redirect and training of the same instruction occur in the same cycle. The next ID cycle holds a flushed bubble (id_valid=0).
- Counter arithmetic is 2-bit saturating. 11 on taken stays 11; 00 on not-taken stays 00.
- PC arithmetic is modulo 2^XLEN; 32'hFFFFFFFF+1 wraps to 0.

## Test plan
- Reset, then lookup if_pc=0x40 -> if_pred_taken=0, if_pred_target=0x41. beq at id_pc=0x40, rs=rt=5, imm=4, pred 0 -> id_redirect=1, pc 0x45. Next cycle lookup 0x40 -> taken, target 0x45.
- Same beq taken twice more, then not taken with pred 1 -> counters 10→11→11→10. Redirect to 0x41 with prediction still taken afterward. Two not-taken -> prediction 0.
- bltz rs=0x80000000 -> taken. bgtz rs=0 -> not taken. blez rs=0 -> taken. Verify signed compare.
- jr rs=0x1234 predicted taken with target 0x1200 -> redirect to 0x1234, no table write. Branch_cnt +1, mispredict_cnt +1.
- Aliasing: IDX_W=6, taken branch at 0x40 then lookup 0x80 (same index, different tag) -> not predicted. id_stall=1 during a mispredicted branch -> no redirect, table unchanged.
- Preload counters to 2^CNT_W-1 (CNT_W=4) -> further mispredicts leave 4'hF. Assert rst_n low mid-training -> all state cleared immediately.

Source files
------------

// File: rtl/id_branch_predictor.sv
// Branch prediction (IF lookup into a direct-mapped 2-bit counter table + BTB)
// and branch/jump resolution in ID with redirect, table training and statistics.
module id_branch_predictor #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 6,
    parameter int TAG_W = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    output logic [XLEN-1:0]  if_pred_target,
    input  logic             id_valid,
    input  logic             id_stall,
    input  logic [XLEN-1:0]  id_pc,
    input  logic             id_pred_taken,
    input  logic [XLEN-1:0]  id_pred_target,
    input  logic             id_branch,
    input  logic [2:0]       id_branch_op,
    input  logic             id_jump,
    input  logic             id_jumpr,
    input  logic [25:0]      id_instr_index,
    input  logic [XLEN-1:0]  id_sign_imm,
    input  logic [XLEN-1:0]  id_rs_val,
    input  logic [XLEN-1:0]  id_rt_val,
    output logic             id_redirect,
    output logic [XLEN-1:0]  id_redirect_pc,
    output logic             id_taken,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int DEPTH = 1 << IDX_W;

    logic             valid_q [DEPTH];
    logic [TAG_W-1:0] tag_q   [DEPTH];
    logic [XLEN-1:0]  tgt_q   [DEPTH];
    logic [1:0]       ctr_q   [DEPTH];

    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    logic [IDX_W-1:0] id_idx;
    logic [TAG_W-1:0] id_tag;
    logic             id_hit;
    logic [1:0]       ctr_cur;

    logic [XLEN-1:0]  pc_p1;
    logic [XLEN-1:0]  j_target;
    logic [XLEN-1:0]  target;
    logic             cond;
    logic             act;
    logic             mis;

    logic             ent_we;
    logic [TAG_W-1:0] ent_tag_d;
    logic [XLEN-1:0]  ent_tgt_d;
    logic [1:0]       ent_ctr_d;

    // IF lookup; no bypass of a same-cycle write, so the old entry is seen.
    assign if_idx         = if_pc[IDX_W-1:0];
    assign if_tag         = if_pc[IDX_W+TAG_W-1:IDX_W];
    assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign if_pred_taken  = if_hit & ctr_q[if_idx][1];
    assign if_pred_target = if_pred_taken ? tgt_q[if_idx] : if_pc + XLEN'(1);

    assign pc_p1    = id_pc + XLEN'(1);
    assign j_target = {pc_p1[XLEN-1:XLEN-4], {(XLEN-30){1'b0}}, id_instr_index};

    always_comb begin
        cond = 1'b0;
        case (id_branch_op)
            3'd0:    cond = (id_rs_val == id_rt_val);
            3'd1:    cond = ~id_rs_val[XLEN-1];
            3'd2:    cond = ~id_rs_val[XLEN-1] & (|id_rs_val);
            3'd3:    cond = id_rs_val[XLEN-1] | ~(|id_rs_val);
            3'd4:    cond = id_rs_val[XLEN-1];
            3'd5:    cond = (id_rs_val != id_rt_val);
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        target = pc_p1 + id_sign_imm;
        if (id_jump) begin
            target = id_jumpr ? id_rs_val : j_target;
        end
    end

    assign id_taken       = id_jump | (id_branch & cond);
    assign act            = id_valid & ~id_stall & (id_branch | id_jump);
    assign mis            = (id_taken != id_pred_taken) ||
                            (id_taken && id_pred_taken && (target != id_pred_target));
    // A non-control instruction predicted taken is a stale alias and must also be undone.
    assign id_redirect    = (act & mis) |
                            (id_valid & ~id_stall & ~id_branch & ~id_jump & id_pred_taken);
    assign id_redirect_pc = id_taken ? target : pc_p1;

    assign id_idx  = id_pc[IDX_W-1:0];
    assign id_tag  = id_pc[IDX_W+TAG_W-1:IDX_W];
    assign id_hit  = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
    assign ctr_cur = ctr_q[id_idx];

    always_comb begin
        ent_we    = 1'b0;
        ent_tag_d = id_tag;
        ent_tgt_d = tgt_q[id_idx];
        ent_ctr_d = ctr_cur;
        if (act) begin
            if (id_jump) begin
                if (!id_jumpr) begin
                    ent_we    = 1'b1;
                    ent_tgt_d = target;
                    ent_ctr_d = 2'b11;
                end
            end else if (id_hit) begin
                ent_we = 1'b1;
                if (id_taken) begin
                    ent_tgt_d = target;
                    ent_ctr_d = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'd1;
                end else begin
                    ent_ctr_d = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'd1;
                end
            end else if (id_taken) begin
                ent_we    = 1'b1;
                ent_tgt_d = target;
                ent_ctr_d = 2'b10;
            end
        end
    end

    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (act && !(&branch_cnt_q)) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (id_redirect && !(&mispredict_cnt_q)) begin
            mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (ent_we) begin
            valid_q[id_idx] <= 1'b1;
            tag_q[id_idx]   <= ent_tag_d;
            tgt_q[id_idx]   <= ent_tgt_d;
            ctr_q[id_idx]   <= ent_ctr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_id_branch_predictor.sv
// Directed-vector bench for id_branch_predictor with a queue scoreboard;
// the DUT uses 4-bit statistics so saturation is reachable quickly.
module tb_id_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        id_valid;
    logic        id_stall;
    logic [31:0] id_pc;
    logic        id_pred_taken;
    logic [31:0] id_pred_target;
    logic        id_branch;
    logic [2:0]  id_branch_op;
    logic        id_jump;
    logic        id_jumpr;
    logic [25:0] id_instr_index;
    logic [31:0] id_sign_imm;
    logic [31:0] id_rs_val;
    logic [31:0] id_rt_val;
    logic        id_redirect;
    logic [31:0] id_redirect_pc;
    logic        id_taken;
    logic [3:0]  branch_cnt;
    logic [3:0]  mispredict_cnt;

    id_branch_predictor #(.XLEN(32), .IDX_W(6), .TAG_W(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_pc(if_pc), .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
        .id_valid(id_valid), .id_stall(id_stall), .id_pc(id_pc),
        .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
        .id_branch(id_branch), .id_branch_op(id_branch_op),
        .id_jump(id_jump), .id_jumpr(id_jumpr), .id_instr_index(id_instr_index),
        .id_sign_imm(id_sign_imm), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
        .id_redirect(id_redirect), .id_redirect_pc(id_redirect_pc), .id_taken(id_taken),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        pt;
        logic [31:0] ptgt;
        logic        tk;
        logic        rd;
        logic [31:0] rpc;
        logic [3:0]  br;
        logic [3:0]  mis;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic [3:0] m_br  = '0;
    logic [3:0] m_mis = '0;

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            logic bad;
            e   = sbq.pop_front();
            bad = 1'b0;
            n_vec++;
            if (if_pred_taken !== e.pt) begin
                $display("FAIL %s pred_taken got %0b want %0b", e.nm, if_pred_taken, e.pt); bad = 1'b1;
            end
            if (if_pred_target !== e.ptgt) begin
                $display("FAIL %s pred_target got %h want %h", e.nm, if_pred_target, e.ptgt); bad = 1'b1;
            end
            if (id_taken !== e.tk) begin
                $display("FAIL %s taken got %0b want %0b", e.nm, id_taken, e.tk); bad = 1'b1;
            end
            if (id_redirect !== e.rd) begin
                $display("FAIL %s redirect got %0b want %0b", e.nm, id_redirect, e.rd); bad = 1'b1;
            end
            if (id_redirect_pc !== e.rpc) begin
                $display("FAIL %s redirect_pc got %h want %h", e.nm, id_redirect_pc, e.rpc); bad = 1'b1;
            end
            if (branch_cnt !== e.br) begin
                $display("FAIL %s branch_cnt got %0d want %0d", e.nm, branch_cnt, e.br); bad = 1'b1;
            end
            if (mispredict_cnt !== e.mis) begin
                $display("FAIL %s mispredict_cnt got %0d want %0d", e.nm, mispredict_cnt, e.mis); bad = 1'b1;
            end
            if (bad) n_bad++;
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_stall = 0; id_pc = '0; id_pred_taken = 0; id_pred_target = '0;
        id_branch = 0; id_branch_op = '0; id_jump = 0; id_jumpr = 0; id_instr_index = '0;
        id_sign_imm = '0; id_rs_val = '0; id_rt_val = '0;
    endtask

    task automatic br(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [31:0] imm, input logic pt,
                      input logic [31:0] ptgt);
        idle();
        id_valid = 1; id_branch = 1; id_branch_op = op; id_pc = pc;
        id_rs_val = rs; id_rt_val = rt; id_sign_imm = imm;
        id_pred_taken = pt; id_pred_target = ptgt;
    endtask

    task automatic jmp(input logic r, input logic [31:0] pc, input logic [25:0] idx,
                       input logic [31:0] rs, input logic pt, input logic [31:0] ptgt);
        idle();
        id_valid = 1; id_jump = 1; id_jumpr = r; id_pc = pc;
        id_instr_index = idx; id_rs_val = rs;
        id_pred_taken = pt; id_pred_target = ptgt;
    endtask

    // Statistics expectations follow from the vector's own expected redirect.
    task automatic chk(input string nm, input logic [31:0] ifpc, input logic e_pt,
                       input logic [31:0] e_ptgt, input logic e_tk, input logic e_rd,
                       input logic [31:0] e_rpc);
        exp_t e;
        if_pc = ifpc;
        if (!rst_n) begin
            m_br  = '0;
            m_mis = '0;
        end
        e.nm = nm; e.pt = e_pt; e.ptgt = e_ptgt; e.tk = e_tk; e.rd = e_rd; e.rpc = e_rpc;
        e.br = m_br; e.mis = m_mis;
        sbq.push_back(e);
        if (rst_n) begin
            if (id_valid && !id_stall && (id_branch || id_jump) && m_br != 4'hF) m_br++;
            if (e_rd && m_mis != 4'hF) m_mis++;
        end
    endtask

    initial begin
        rst_n = 0;
        if_pc = '0;
        idle();

        next(); idle();                          chk("reset",      32'h40, 0, 32'h41, 0, 0, 32'h1);
        next(); rst_n = 1;
        br(0, 32'h40, 5, 5, 4, 0, 0);            chk("beq_first",  32'h40, 0, 32'h41, 1, 1, 32'h45);
        next(); idle();                          chk("lookup_10",  32'h40, 1, 32'h45, 0, 0, 32'h1);
        next(); br(0, 32'h40, 5, 5, 4, 1, 32'h45); chk("beq_t2",   32'h40, 1, 32'h45, 1, 0, 32'h45);
        next(); br(0, 32'h40, 5, 5, 4, 1, 32'h45); chk("beq_t3",   32'h40, 1, 32'h45, 1, 0, 32'h45);
        next(); br(0, 32'h40, 5, 6, 4, 1, 32'h45); chk("beq_nt1",  32'h40, 1, 32'h45, 0, 1, 32'h41);
        next(); idle();                          chk("lookup_10b", 32'h40, 1, 32'h45, 0, 0, 32'h1);
        next(); br(0, 32'h40, 5, 6, 4, 1, 32'h45); chk("beq_nt2",  32'h40, 1, 32'h45, 0, 1, 32'h41);
        next(); br(0, 32'h40, 5, 6, 4, 0, 0);    chk("beq_nt3",    32'h40, 0, 32'h41, 0, 0, 32'h41);
        next(); idle();                          chk("lookup_00",  32'h40, 0, 32'h41, 0, 0, 32'h1);

        next(); br(4, 32'h10, 32'h80000000, 0, 2, 0, 0);      chk("bltz_neg", 32'h10, 0, 32'h11, 1, 1, 32'h13);
        next(); br(2, 32'h20, 0, 0, 2, 0, 0);                 chk("bgtz_0",   32'h10, 1, 32'h13, 0, 0, 32'h21);
        next(); br(3, 32'h30, 0, 0, 32'hFFFFFFFD, 0, 0);      chk("blez_0",   32'h20, 0, 32'h21, 1, 1, 32'h2E);
        next(); br(1, 32'h50, 32'hFFFFFFFF, 0, 4, 1, 32'h55); chk("bgez_neg", 32'h30, 1, 32'h2E, 0, 1, 32'h51);
        next(); br(5, 32'h60, 1, 2, 32'h10, 0, 0);            chk("bne_ne",   32'h50, 0, 32'h51, 1, 1, 32'h71);

        next(); jmp(1, 32'h200, 0, 32'h1234, 1, 32'h1200);    chk("jr_mis",   32'h200, 0, 32'h201, 1, 1, 32'h1234);
        next(); idle();                                       chk("jr_nowr",  32'h200, 0, 32'h201, 0, 0, 32'h1);
        next(); jmp(0, 32'h300, 26'hABC, 0, 0, 0);            chk("j_alloc",  32'h300, 0, 32'h301, 1, 1, 32'hABC);
        next(); idle();                                       chk("j_ctr11",  32'h300, 1, 32'hABC, 0, 0, 32'h1);
        next(); idle();                                       chk("j_alias",  32'h40, 0, 32'h41, 0, 0, 32'h1);

        next(); br(0, 32'h40, 5, 5, 4, 0, 0);                 chk("alias_br", 32'h80, 0, 32'h81, 1, 1, 32'h45);
        next(); idle();                                       chk("alias_80", 32'h80, 0, 32'h81, 0, 0, 32'h1);
        next(); idle();                                       chk("alias_40", 32'h40, 1, 32'h45, 0, 0, 32'h1);
        next(); br(0, 32'h40, 5, 6, 4, 1, 32'h45); id_stall = 1;
                                                              chk("stall",    32'h40, 1, 32'h45, 0, 0, 32'h41);
        next(); idle();                                       chk("stall_tbl", 32'h40, 1, 32'h45, 0, 0, 32'h1);
        next(); idle(); id_valid = 1; id_pc = 32'h500; id_pred_taken = 1; id_pred_target = 32'h999;
                                                              chk("stale_nb", 32'h40, 1, 32'h45, 0, 1, 32'h501);

        for (int i = 0; i < 6; i++) begin
            next(); br(5, 32'h600, 1, 1, 0, 1, 32'h700);      chk("sat",      32'h40, 1, 32'h45, 0, 1, 32'h601);
        end
        next(); br(0, 32'hFFFFFFFF, 7, 7, 0, 0, 0);           chk("pc_wrap",  32'hFFFFFFFF, 0, 32'h0, 1, 1, 32'h0);
        next(); idle();                                       chk("wrap_tbl", 32'hFFFFFFFF, 1, 32'h0, 0, 0, 32'h1);

        next(); rst_n = 0; br(0, 32'h40, 5, 5, 4, 0, 0);      chk("rst_mid",  32'h40, 0, 32'h41, 1, 1, 32'h45);
        next(); rst_n = 1; idle();                            chk("rst_clr1", 32'hFFFFFFFF, 0, 32'h0, 0, 0, 32'h1);
        next(); idle();                                       chk("rst_clr2", 32'h40, 0, 32'h41, 0, 0, 32'h1);

        next();
        next();
        if (sbq.size() != 0) begin
            $display("FAIL drain pending got %0d want 0", sbq.size());
            n_bad++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
